decoder_n_seq: RTL and testbench

- Parametrised, registered binary decoder: IN_W-bit code to 2**IN_W-bit output, with a valid/ready input handshake.
- Four output modes: one-hot, thermometer, inverted one-hot, and auto-scan.
- Each accepted code is driven for a programmable number of cycles (hold), then released.
- Used as the select/strobe generator for downstream banks where a plain combinational decoder lacks timing control and sequencing.

---
 rtl/decoder_n_seq.sv | 189 ++++++++++++++++++
 tb/tb_decoder_n_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_n_seq.sv
// -----------------------------------------------------------------------------
// decoder_n_seq
//
// Registered, sequenced binary decoder. An IN_W-bit code accepted through a
// valid/ready handshake is decoded onto a 2**IN_W-bit strobe bus. The decoded
// value is held for HOLD_CYC cycles and then released, with a one-cycle done
// pulse. Scan mode walks one-hot through every code once, starting at the
// accepted code, holding each for HOLD_CYC cycles.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : code request present
//   in_ready   : block can accept (high only while idle)
//   in_code    : binary code to decode
//   mode       : 00 one-hot, 01 thermometer, 10 scan, 11 inverted one-hot
//   abort      : synchronous cancel of the running operation
//   out        : registered decoded value (all-zeros when idle, in every mode)
//   out_valid  : out carries a decoded value
//   cur_code   : code currently driven on out
//   done       : one-cycle pulse when an operation completes or is aborted
// -----------------------------------------------------------------------------
module decoder_n_seq #(
  parameter int IN_W     = 3,
  parameter int HOLD_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_code,
  input  logic [1:0]            mode,
  input  logic                  abort,
  output logic [(2**IN_W)-1:0]  out,
  output logic                  out_valid,
  output logic [IN_W-1:0]       cur_code,
  output logic                  done
);

  localparam int OUT_W  = 2**IN_W;
  localparam int HCNT_W = $clog2(HOLD_CYC + 1);

  // Counter reload: the cycle the value first appears counts as one of the
  // HOLD_CYC cycles, so the counter runs HOLD_CYC-1 .. 0.
  localparam logic [HCNT_W-1:0] HOLD_LOAD = HCNT_W'(HOLD_CYC - 1);
  // A scan covers OUT_W codes: the accepted one plus OUT_W-1 steps.
  localparam logic [IN_W-1:0]   SCAN_LAST = IN_W'(OUT_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'b00,
    MODE_THERM  = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_INV    = 2'b11
  } mode_e;

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [OUT_W-1:0]    out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic [IN_W-1:0]     cur_code_q, cur_code_d;
  logic [IN_W-1:0]     scan_left_q, scan_left_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic                done_q, done_d;

  mode_e               req_mode;
  logic [IN_W-1:0]     next_code;
  logic                hold_expired;
  logic                finish_op;

  // Decoded value for a code; scan uses the one-hot rule on its current code.
  function automatic logic [OUT_W-1:0] decode(input logic [IN_W-1:0] code,
                                              input mode_e            m);
    logic [OUT_W-1:0] v;
    v = '0;
    for (int i = 0; i < OUT_W; i++) begin
      case (m)
        MODE_THERM: v[i] = (i <= int'(code));
        MODE_INV:   v[i] = (i != int'(code));
        default:    v[i] = (i == int'(code));
      endcase
    end
    return v;
  endfunction

  assign req_mode     = mode_e'(mode);
  assign next_code    = cur_code_q + IN_W'(1);   // wraps OUT_W-1 -> 0
  assign hold_expired = (hcnt_q == '0);

  // An operation ends on abort, or when the hold of its last value expires.
  // Abort wins over expiry simply by being OR-ed in: both lead to the same
  // single termination, so a coincident abort yields one done pulse.
  assign finish_op = abort ||
                     (hold_expired &&
                      ((state_q == ST_HOLD) || (scan_left_q == '0)));

  // Next-state and datapath.
  // NOTE: every variable assigned here receives a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    cur_code_d  = cur_code_q;
    scan_left_d = scan_left_q;
    hcnt_d      = hcnt_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Abort in idle has no effect other than suppressing an accept.
        if (in_valid && !abort) begin
          mode_d      = req_mode;
          cur_code_d  = in_code;
          out_d       = decode(in_code, req_mode);
          out_valid_d = 1'b1;
          hcnt_d      = HOLD_LOAD;
          scan_left_d = SCAN_LAST;
          state_d     = (req_mode == MODE_SCAN) ? ST_SCAN : ST_HOLD;
        end
      end

      ST_HOLD, ST_SCAN: begin
        if (finish_op) begin
          // cur_code keeps the last driven code; out_valid qualifies it.
          out_d       = '0;
          out_valid_d = 1'b0;
          hcnt_d      = '0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end else if (hold_expired) begin
          // Only reachable in scan with codes still to visit.
          cur_code_d  = next_code;
          out_d       = decode(next_code, MODE_ONEHOT);
          hcnt_d      = HOLD_LOAD;
          scan_left_d = scan_left_q - IN_W'(1);
        end else begin
          hcnt_d      = hcnt_q - HCNT_W'(1);
        end
      end

      default: begin
        out_d       = '0;
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others regardless of statement order.
  // NOTE: all flops here are control or small datapath registers, so every one
  // is reset; asynchronous reset clears the outputs without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_ONEHOT;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      cur_code_q  <= '0;
      scan_left_q <= '0;
      hcnt_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      cur_code_q  <= cur_code_d;
      scan_left_q <= scan_left_d;
      hcnt_q      <= hcnt_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign cur_code  = cur_code_q;
  assign done      = done_q;

endmodule

// File: tb/tb_decoder_n_seq.sv
// -----------------------------------------------------------------------------
// tb_decoder_n_seq
//
// Self-checking bench for decoder_n_seq (IN_W=3, HOLD_CYC=4): a table of
// single-code operations, hand-written multi-cycle sequences (scan wrap,
// backpressure, abort, asynchronous reset) and a randomized run against a
// behavioural model that predicts outputs from the elapsed cycle count.
// -----------------------------------------------------------------------------
module tb_decoder_n_seq;

  localparam int IN_W     = 3;
  localparam int HOLD_CYC = 4;
  localparam int OUT_W    = 2**IN_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_code;
  logic [1:0]        mode;
  logic              abort;
  logic [OUT_W-1:0]  out;
  logic              out_valid;
  logic [IN_W-1:0]   cur_code;
  logic              done;

  int checks = 0;
  int errors = 0;

  decoder_n_seq #(.IN_W(IN_W), .HOLD_CYC(HOLD_CYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .mode      (mode),
    .abort     (abort),
    .out       (out),
    .out_valid (out_valid),
    .cur_code  (cur_code),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IN_W-1:0]  code;
    logic [1:0]       mode;
    logic [OUT_W-1:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then sampled 1 time unit
  // after it and inputs driven there remain stable until the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int code, input int m);
    check("accept_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_code  = IN_W'(code);
    mode     = 2'(m);
    tick();
    in_valid = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  bit m_active;
  bit m_done;
  int m_code, m_mode, m_el, m_total, m_last;

  function automatic int ref_cur(int c, int m, int el);
    if (m == 2) return (c + el / HOLD_CYC) % OUT_W;
    return c;
  endfunction

  function automatic logic [OUT_W-1:0] ref_out(int c, int m, int el);
    logic [OUT_W-1:0] one;
    one = OUT_W'(1);
    case (m)
      0:       return one << c;
      1:       return OUT_W'((2 << c) - 1);
      3:       return ~(one << c);
      default: return one << ref_cur(c, m, el);
    endcase
  endfunction

  task automatic model_step(input bit v, input int c, input int m,
                            input bit a);
    if (m_active) begin
      if (a || (m_el == m_total - 1)) begin
        m_last   = ref_cur(m_code, m_mode, m_el);
        m_active = 1'b0;
        m_done   = 1'b1;
      end else begin
        m_el++;
        m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
      if (v && !a) begin
        m_active = 1'b1;
        m_el     = 0;
        m_code   = c;
        m_mode   = m;
        m_total  = (m == 2) ? OUT_W * HOLD_CYC : HOLD_CYC;
      end
    end
  endtask

  initial begin
    int scan_seq [8];
    int sc;

    vecs[0] = '{code: 3'd5, mode: 2'b00, exp: 8'h20};
    vecs[1] = '{code: 3'd2, mode: 2'b01, exp: 8'h07};
    vecs[2] = '{code: 3'd0, mode: 2'b11, exp: 8'hFE};
    vecs[3] = '{code: 3'd7, mode: 2'b01, exp: 8'hFF};
    vecs[4] = '{code: 3'd3, mode: 2'b11, exp: 8'hF7};
    vecs[5] = '{code: 3'd0, mode: 2'b00, exp: 8'h01};
    scan_seq = '{6, 7, 0, 1, 2, 3, 4, 5};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_code  = '0;
    mode     = 2'b00;
    abort    = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_out", 32'(out), 32'h0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cur", 32'(cur_code), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", 32'(in_ready), 32'd1);

    // ---------------- table-driven single operations ----------------
    foreach (vecs[i]) begin
      accept(int'(vecs[i].code), int'(vecs[i].mode));
      for (int k = 0; k < HOLD_CYC; k++) begin
        check("vec_out", 32'(out), 32'(vecs[i].exp));
        check("vec_valid", 32'(out_valid), 32'd1);
        check("vec_cur", 32'(cur_code), 32'(vecs[i].code));
        check("vec_ready", 32'(in_ready), 32'd0);
        check("vec_done_early", 32'(done), 32'd0);
        tick();
      end
      check("vec_end_out", 32'(out), 32'h0);
      check("vec_end_valid", 32'(out_valid), 32'd0);
      check("vec_end_done", 32'(done), 32'd1);
      check("vec_end_ready", 32'(in_ready), 32'd1);
      tick();
      check("vec_done_once", 32'(done), 32'd0);
    end

    // ---------------- scan with wrap ----------------
    accept(6, 2);
    for (int k = 0; k < OUT_W * HOLD_CYC; k++) begin
      sc = scan_seq[k / HOLD_CYC];
      check("scan_cur", 32'(cur_code), 32'(sc));
      check("scan_out", 32'(out), 32'(1) << sc);
      check("scan_valid", 32'(out_valid), 32'd1);
      check("scan_done_early", 32'(done), 32'd0);
      tick();
    end
    check("scan_end_done", 32'(done), 32'd1);
    check("scan_end_valid", 32'(out_valid), 32'd0);
    check("scan_end_out", 32'(out), 32'h0);
    tick();

    // ---------------- backpressure ----------------
    accept(2, 0);
    in_valid = 1'b1;
    in_code  = 3'd3;
    tick();
    tick();
    in_code = 3'd1;
    check("bp_hold_out", 32'(out), 32'h04);
    check("bp_hold_cur", 32'(cur_code), 32'd2);
    tick();
    tick();
    check("bp_done", 32'(done), 32'd1);
    check("bp_idle_out", 32'(out), 32'h0);
    tick();
    in_valid = 1'b0;
    check("bp_new_cur", 32'(cur_code), 32'd1);
    check("bp_new_out", 32'(out), 32'h02);
    check("bp_new_valid", 32'(out_valid), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("bp_abort_done", 32'(done), 32'd1);
    tick();

    // ---------------- abort in scan at cur_code 0 ----------------
    accept(6, 2);
    for (int k = 0; k < 2 * HOLD_CYC; k++) tick();
    check("ab_scan_cur", 32'(cur_code), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_scan_out", 32'(out), 32'h0);
    check("ab_scan_valid", 32'(out_valid), 32'd0);
    check("ab_scan_done", 32'(done), 32'd1);
    check("ab_scan_ready", 32'(in_ready), 32'd1);
    tick();
    check("ab_scan_done_once", 32'(done), 32'd0);

    // ---------------- abort on the final hold cycle ----------------
    accept(4, 0);
    for (int k = 0; k < HOLD_CYC - 1; k++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_last_done", 32'(done), 32'd1);
    check("ab_last_valid", 32'(out_valid), 32'd0);
    tick();
    check("ab_last_done_once", 32'(done), 32'd0);

    // ---------------- abort in idle blocks accept ----------------
    in_valid = 1'b1;
    in_code  = 3'd1;
    abort    = 1'b1;
    tick();
    in_valid = 1'b0;
    abort    = 1'b0;
    check("ab_idle_valid", 32'(out_valid), 32'd0);
    check("ab_idle_ready", 32'(in_ready), 32'd1);
    check("ab_idle_done", 32'(done), 32'd0);

    // ---------------- asynchronous reset mid-hold ----------------
    accept(5, 0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out", 32'(out), 32'h0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_cur", 32'(cur_code), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    tick();
    check("arst_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_idle_valid", 32'(out_valid), 32'd0);

    // ---------------- randomized run vs. model ----------------
    m_active = 1'b0;
    m_done   = 1'b0;
    m_last   = 0;
    m_code   = 0;
    m_mode   = 0;
    m_el     = 0;
    m_total  = HOLD_CYC;
    for (int n = 0; n < 1500; n++) begin
      bit rv, ra;
      int rc, rm;
      check("rnd_valid", 32'(out_valid), 32'(m_active));
      check("rnd_ready", 32'(in_ready), 32'(!m_active));
      check("rnd_done", 32'(done), 32'(m_done));
      check("rnd_out", 32'(out),
            m_active ? 32'(ref_out(m_code, m_mode, m_el)) : 32'h0);
      check("rnd_cur", 32'(cur_code),
            32'(m_active ? ref_cur(m_code, m_mode, m_el) : m_last));
      rv = ($urandom_range(0, 2) != 0);
      ra = ($urandom_range(0, 24) == 0);
      rc = int'($urandom_range(0, OUT_W - 1));
      rm = int'($urandom_range(0, 3));
      in_valid = rv;
      abort    = ra;
      in_code  = IN_W'(rc);
      mode     = 2'(rm);
      tick();
      model_step(rv, rc, rm, ra);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
